// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
//
// Round-robin front end that shares one sequential divider between N_REQ
// requesters. One operation is in flight at a time: a request is granted in
// IDLE, the divider runs in WAIT, and the result is offered in RESP until
// the consumer takes it. A zero divisor skips the divider and answers with
// quotient = all ones, remainder = dividend and the rsp_dz flag set.
//
// Handshake rule (both sides): a transfer happens on the rising clk edge
// where valid and ready are both high. Request side: req_ready is
// combinational, one-hot on the granted requester, and only in IDLE while
// div_done is low. Response side: rsp_valid holds with stable payload until
// the edge where rsp_ready is high.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   req_valid / req_ready       per-requester request handshake (N_REQ bits)
//   req_dividend / req_divisor  packed operands, requester i at [i*BIT_DEPTH +: BIT_DEPTH]
//   rsp_valid / rsp_ready       response handshake
//   rsp_id                      requester index that was served
//   rsp_quotient / rsp_remainder / rsp_dz   result and divide-by-zero flag
//   div_start                   held high until the divider reports div_done
//   div_dividend / div_divisor  operands to the divider
//   div_done / div_quotient / div_remainder  divider completion and result
//   busy                        high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module div_arbiter #(
    parameter  int BIT_DEPTH = 32,
    parameter  int N_REQ     = 4,
    localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*BIT_DEPTH-1:0] req_dividend,
    input  logic [N_REQ*BIT_DEPTH-1:0] req_divisor,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [BIT_DEPTH-1:0]       rsp_quotient,
    output logic [BIT_DEPTH-1:0]       rsp_remainder,
    output logic                       rsp_dz,
    output logic                       div_start,
    output logic [BIT_DEPTH-1:0]       div_dividend,
    output logic [BIT_DEPTH-1:0]       div_divisor,
    input  logic                       div_done,
    input  logic [BIT_DEPTH-1:0]       div_quotient,
    input  logic [BIT_DEPTH-1:0]       div_remainder,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q;
    logic [ID_W-1:0]       last_grant_q;
    logic [ID_W-1:0]       rsp_id_q;
    logic [BIT_DEPTH-1:0]  rsp_quotient_q;
    logic [BIT_DEPTH-1:0]  rsp_remainder_q;
    logic                  rsp_dz_q;
    logic                  div_start_q;
    logic [BIT_DEPTH-1:0]  div_dividend_q;
    logic [BIT_DEPTH-1:0]  div_divisor_q;

    logic [ID_W-1:0]       grant_id_d;
    logic                  grant_found_d;
    logic [ID_W-1:0]       cand_d;
    logic                  accept_d;
    logic [BIT_DEPTH-1:0]  acc_dividend_d;
    logic [BIT_DEPTH-1:0]  acc_divisor_d;

    // Round-robin search starting one past the last grant. The candidate
    // index is computed as an int so that the wrap works for any N_REQ,
    // not just powers of two.
    always_comb begin
        grant_id_d    = '0;
        grant_found_d = 1'b0;
        cand_d        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_d = ID_W'((int'(last_grant_q) + k) % N_REQ);
            if (!grant_found_d && req_valid[cand_d]) begin
                grant_found_d = 1'b1;
                grant_id_d    = cand_d;
            end
        end
    end

    // req_ready is also forced low during reset so every output reads 0
    // while reset is held, even with requests pending.
    always_comb begin
        req_ready = '0;
        if (!reset && state_q == IDLE && !div_done && grant_found_d) begin
            req_ready[grant_id_d] = 1'b1;
        end
    end

    assign accept_d       = |(req_valid & req_ready);
    assign acc_dividend_d = req_dividend[grant_id_d*BIT_DEPTH +: BIT_DEPTH];
    assign acc_divisor_d  = req_divisor[grant_id_d*BIT_DEPTH +: BIT_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            last_grant_q    <= ID_W'(N_REQ - 1);
            rsp_id_q        <= '0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_dz_q        <= 1'b0;
            div_start_q     <= 1'b0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        last_grant_q   <= grant_id_d;
                        rsp_id_q       <= grant_id_d;
                        div_dividend_q <= acc_dividend_d;
                        div_divisor_q  <= acc_divisor_d;
                        if (acc_divisor_d == '0) begin
                            // Answer locally; the divider is never started.
                            rsp_quotient_q  <= '1;
                            rsp_remainder_q <= acc_dividend_d;
                            rsp_dz_q        <= 1'b1;
                            state_q         <= RESP;
                        end else begin
                            div_start_q <= 1'b1;
                            state_q     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (div_done) begin
                        rsp_quotient_q  <= div_quotient;
                        rsp_remainder_q <= div_remainder;
                        rsp_dz_q        <= 1'b0;
                        div_start_q     <= 1'b0;
                        state_q         <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    div_start_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid     = (state_q == RESP);
    assign busy          = (state_q != IDLE);
    assign rsp_id        = rsp_id_q;
    assign rsp_quotient  = rsp_quotient_q;
    assign rsp_remainder = rsp_remainder_q;
    assign rsp_dz        = rsp_dz_q;
    assign div_start     = div_start_q;
    assign div_dividend  = div_dividend_q;
    assign div_divisor   = div_divisor_q;

endmodule

// File: tb/tb_div_arbiter.sv
// -----------------------------------------------------------------------------
// tb_div_arbiter
//
// Directed bench for div_arbiter (BIT_DEPTH=32, N_REQ=4). A small behavioural
// divider answers div_start after a fixed latency. Inputs are driven just
// after the falling edge and outputs are sampled one time unit later or on
// the following falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_div_arbiter;

    localparam int BD  = 32;
    localparam int N   = 4;
    localparam int LAT = 3;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*BD-1:0] req_dividend;
    logic [N*BD-1:0] req_divisor;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [BD-1:0] rsp_quotient;
    logic [BD-1:0] rsp_remainder;
    logic          rsp_dz;
    logic          div_start;
    logic [BD-1:0] div_dividend;
    logic [BD-1:0] div_divisor;
    logic          div_done;
    logic [BD-1:0] div_quotient;
    logic [BD-1:0] div_remainder;
    logic          busy;

    int n_pass;
    int n_total;

    div_arbiter #(.BIT_DEPTH(BD), .N_REQ(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_dz(rsp_dz),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .busy(busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural divider ----------------
    logic          m_done;
    logic [BD-1:0] m_q;
    logic [BD-1:0] m_r;
    int            m_cnt;
    logic          spur_done;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_q    <= '0;
            m_r    <= '0;
        end else begin
            m_done <= 1'b0;
            if (div_start && !m_done) begin
                if (m_cnt == LAT - 1) begin
                    m_done <= 1'b1;
                    m_cnt  <= 0;
                    m_q    <= (div_divisor == 0) ? '1 : div_dividend / div_divisor;
                    m_r    <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    assign div_done      = m_done | spur_done;
    assign div_quotient  = m_q;
    assign div_remainder = m_r;

    // Sticky monitors, cleared by the tests that use them.
    bit ds_seen;
    bit rsp_seen;
    always @(posedge clk) begin
        if (div_start) ds_seen = 1'b1;
        if (rsp_valid) rsp_seen = 1'b1;
    end

    // ---------------- driver tasks ----------------
    task automatic set_op(input int i, input logic [BD-1:0] a, input logic [BD-1:0] b);
        req_dividend[i*BD +: BD] = a;
        req_divisor[i*BD +: BD]  = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Returns at (negedge + 1) with the granted index, or ok=0 on timeout.
    task automatic wait_grant(output bit ok, output int gid);
        ok  = 1'b0;
        gid = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (req_ready != '0) begin
                ok = 1'b1;
                for (int b = 0; b < N; b++) if (req_ready[b]) gid = b;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Returns with rsp_valid seen high and the number of falling edges waited.
    task automatic wait_rsp(output bit ok, output int cycles);
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        req_valid = '1;
        set_op(0, 32'd5, 32'd1);
        @(negedge clk);
        #1;
        n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b exp 0000", req_ready); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
        n_total++; if (div_start !== 1'b0) $display("FAIL reset_div_start: got %b exp 0", div_start); else n_pass++;
        n_total++; if (rsp_quotient !== 32'd0 || rsp_remainder !== 32'd0 || rsp_dz !== 1'b0 || rsp_id !== 2'd0)
            $display("FAIL reset_rsp_fields: got q=%h r=%h dz=%b id=%0d exp all 0", rsp_quotient, rsp_remainder, rsp_dz, rsp_id); else n_pass++;
        n_total++; if (div_dividend !== 32'd0 || div_divisor !== 32'd0)
            $display("FAIL reset_div_ops: got %h/%h exp 0/0", div_dividend, div_divisor); else n_pass++;
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        int cyc;
        @(negedge clk);
        set_op(0, 32'd100, 32'd4);
        req_valid = 4'b0001;
        #1;
        n_total++; if (req_ready !== 4'b0001) $display("FAIL basic_req_ready: got %b exp 0001", req_ready); else n_pass++;
        @(negedge clk);
        req_valid = '0;
        #1;
        n_total++; if (busy !== 1'b1 || div_start !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL basic_wait_state: got busy=%b start=%b rsp_valid=%b exp 1 1 0", busy, div_start, rsp_valid); else n_pass++;
        n_total++; if (div_dividend !== 32'd100 || div_divisor !== 32'd4)
            $display("FAIL basic_div_ops: got %0d/%0d exp 100/4", div_dividend, div_divisor); else n_pass++;
        wait_rsp(ok, cyc);
        n_total++; if (ok !== 1'b1) $display("FAIL basic_rsp_timeout: got no rsp_valid exp rsp_valid"); else n_pass++;
        n_total++; if (cyc !== LAT + 1) $display("FAIL basic_latency: got %0d exp %0d", cyc, LAT + 1); else n_pass++;
        n_total++; if (rsp_id !== 2'd0 || rsp_quotient !== 32'd25 || rsp_remainder !== 32'd0 || rsp_dz !== 1'b0)
            $display("FAIL basic_result: got id=%0d q=%0d r=%0d dz=%b exp 0 25 0 0", rsp_id, rsp_quotient, rsp_remainder, rsp_dz); else n_pass++;
        n_total++; if (div_start !== 1'b0) $display("FAIL basic_start_drop: got %b exp 0", div_start); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (busy !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL basic_back_idle: got busy=%b rsp_valid=%b exp 0 0", busy, rsp_valid); else n_pass++;
    endtask

    task automatic test_round_robin();
        bit ok;
        int gid;
        int cyc;
        int exp_q[3] = '{22, 16, 257};
        int exp_r[3] = '{2, 0, 0};
        do_reset();
        set_op(0, 32'd1234, 32'd56);
        set_op(1, 32'd256, 32'd16);
        set_op(2, 32'd65535, 32'd255);
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            wait_grant(ok, gid);
            n_total++; if (ok !== 1'b1 || gid !== k) $display("FAIL rr_grant%0d: got %0d exp %0d", k, gid, k); else n_pass++;
            @(negedge clk);
            if (gid >= 0) req_valid[gid] = 1'b0;
            wait_rsp(ok, cyc);
            n_total++; if (ok !== 1'b1 || rsp_id !== 2'(k) || rsp_quotient !== 32'(exp_q[k]) || rsp_remainder !== 32'(exp_r[k]))
                $display("FAIL rr_result%0d: got id=%0d q=%0d r=%0d exp %0d %0d %0d", k, rsp_id, rsp_quotient, rsp_remainder, k, exp_q[k], exp_r[k]); else n_pass++;
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_div_zero();
        bit ok;
        int gid;
        @(negedge clk);
        ds_seen = 1'b0;
        set_op(1, 32'd100, 32'd0);
        req_valid = 4'b0010;
        wait_grant(ok, gid);
        n_total++; if (ok !== 1'b1 || gid !== 1) $display("FAIL dz_grant: got %0d exp 1", gid); else n_pass++;
        @(negedge clk);
        req_valid = '0;
        #1;
        n_total++; if (rsp_valid !== 1'b1) $display("FAIL dz_rsp_valid: got %b exp 1", rsp_valid); else n_pass++;
        n_total++; if (rsp_dz !== 1'b1 || rsp_quotient !== 32'hFFFF_FFFF || rsp_remainder !== 32'd100 || rsp_id !== 2'd1)
            $display("FAIL dz_result: got dz=%b q=%h r=%0d id=%0d exp 1 ffffffff 100 1", rsp_dz, rsp_quotient, rsp_remainder, rsp_id); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL dz_turnaround: got busy=%b exp 0", busy); else n_pass++;
        n_total++; if (ds_seen !== 1'b0) $display("FAIL dz_no_start: got div_start seen=%b exp 0", ds_seen); else n_pass++;
    endtask

    task automatic test_fairness();
        bit ok;
        int gid;
        int cyc;
        int exp_id;
        do_reset();
        set_op(0, 32'd10, 32'd3);
        set_op(3, 32'd20, 32'd7);
        req_valid = 4'b1001;
        for (int k = 0; k < 6; k++) begin
            exp_id = (k % 2 == 0) ? 0 : 3;
            wait_grant(ok, gid);
            n_total++; if (ok !== 1'b1 || gid !== exp_id) $display("FAIL fair_grant%0d: got %0d exp %0d", k, gid, exp_id); else n_pass++;
            @(negedge clk);
            wait_rsp(ok, cyc);
            n_total++; if (ok !== 1'b1 || rsp_id !== 2'(exp_id) || rsp_quotient !== ((exp_id == 0) ? 32'd3 : 32'd2))
                $display("FAIL fair_rsp%0d: got id=%0d q=%0d exp id %0d", k, rsp_id, rsp_quotient, exp_id); else n_pass++;
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int gid;
        int cyc;
        @(negedge clk);
        rsp_ready = 1'b0;
        set_op(0, 32'd50, 32'd5);
        set_op(1, 32'd9, 32'd9);
        req_valid = 4'b0011;
        wait_grant(ok, gid);
        n_total++; if (ok !== 1'b1 || gid !== 0) $display("FAIL bp_grant: got %0d exp 0", gid); else n_pass++;
        @(negedge clk);
        wait_rsp(ok, cyc);
        n_total++; if (ok !== 1'b1) $display("FAIL bp_rsp_timeout: got no rsp_valid exp rsp_valid"); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_quotient !== 32'd10 || rsp_remainder !== 32'd0)
                $display("FAIL bp_hold%0d: got v=%b id=%0d q=%0d r=%0d exp 1 0 10 0", k, rsp_valid, rsp_id, rsp_quotient, rsp_remainder); else n_pass++;
            n_total++; if (req_ready !== 4'b0000 || busy !== 1'b1)
                $display("FAIL bp_blocked%0d: got req_ready=%b busy=%b exp 0000 1", k, req_ready, busy); else n_pass++;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_total++; if (busy !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL bp_release: got busy=%b rsp_valid=%b exp 0 0", busy, rsp_valid); else n_pass++;
        n_total++; if (req_ready !== 4'b0010) $display("FAIL bp_next_grant: got %b exp 0010", req_ready); else n_pass++;
        // Withdraw the pending request before it is accepted.
        req_valid = '0;
        @(negedge clk);
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL drop_no_effect: got busy=%b exp 0", busy); else n_pass++;
    endtask

    task automatic test_spurious_done();
        bit ok;
        int cyc;
        @(negedge clk);
        set_op(1, 32'd9, 32'd3);
        req_valid = 4'b0010;
        spur_done = 1'b1;
        #1;
        n_total++; if (req_ready !== 4'b0000) $display("FAIL spur_ready_masked: got %b exp 0000", req_ready); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (busy !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL spur_idle: got busy=%b rsp_valid=%b exp 0 0", busy, rsp_valid); else n_pass++;
        spur_done = 1'b0;
        #1;
        n_total++; if (req_ready !== 4'b0010) $display("FAIL spur_ready_back: got %b exp 0010", req_ready); else n_pass++;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(ok, cyc);
        n_total++; if (ok !== 1'b1 || rsp_quotient !== 32'd3 || rsp_id !== 2'd1)
            $display("FAIL spur_result: got q=%0d id=%0d exp 3 1", rsp_quotient, rsp_id); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int gid;
        int cyc;
        @(negedge clk);
        set_op(2, 32'd7, 32'd2);
        req_valid = 4'b0100;
        wait_grant(ok, gid);
        n_total++; if (ok !== 1'b1 || gid !== 2) $display("FAIL rst_mid_grant: got %0d exp 2", gid); else n_pass++;
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        n_total++; if (div_start !== 1'b1) $display("FAIL rst_mid_start: got %b exp 1", div_start); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++; if (div_start !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000)
            $display("FAIL rst_mid_async: got start=%b busy=%b v=%b ready=%b exp 0 0 0 0000", div_start, busy, rsp_valid, req_ready); else n_pass++;
        n_total++; if (div_dividend !== 32'd0 || rsp_quotient !== 32'd0)
            $display("FAIL rst_mid_clear: got dd=%0d q=%0d exp 0 0", div_dividend, rsp_quotient); else n_pass++;
        rsp_seen = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        set_op(0, 32'd81, 32'd9);
        req_valid = 4'b0101;
        wait_grant(ok, gid);
        n_total++; if (ok !== 1'b1 || gid !== 0) $display("FAIL rst_mid_regrant: got %0d exp 0", gid); else n_pass++;
        n_total++; if (rsp_seen !== 1'b0) $display("FAIL rst_mid_no_rsp: got rsp seen=%b exp 0", rsp_seen); else n_pass++;
        @(negedge clk);
        req_valid = '0;
        wait_rsp(ok, cyc);
        n_total++; if (ok !== 1'b1 || rsp_id !== 2'd0 || rsp_quotient !== 32'd9 || rsp_remainder !== 32'd0)
            $display("FAIL rst_mid_result: got id=%0d q=%0d r=%0d exp 0 9 0", rsp_id, rsp_quotient, rsp_remainder); else n_pass++;
        @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_pass       = 0;
        n_total      = 0;
        reset        = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = 1'b1;
        spur_done    = 1'b0;
        ds_seen      = 1'b0;
        rsp_seen     = 1'b0;

        test_reset();
        test_basic();
        test_round_robin();
        test_div_zero();
        test_fairness();
        test_backpressure();
        test_spurious_done();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test exp finish before 200000ns");
        $fatal(1);
    end

endmodule
